// File: rtl/monster_fleet_ctrl_pkg.sv
// Shared types and constants for the monster fleet controller.
// Level masks, score limit, load selector and fleet position bundle.
package monster_fleet_ctrl_pkg;

  localparam int NUM_MON = 5;

  localparam logic [NUM_MON-1:0] L1_MASK = 5'b10101;
  localparam logic [NUM_MON-1:0] L2_MASK = 5'b11111;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  typedef enum logic [1:0] {
    LD_NONE,
    LD_L1,
    LD_L2
  } load_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dir;
  } fleet_pos_t;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v
  );
    return (v == SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/monster_fleet_ctrl_fleet_tick_gen.sv
// Fleet march tick: counts 0..STEP_DIV-1 while enabled, pulses on the last.
// Ports: clk, rst, enable_i (count), clear_i (restart at 0), tick_o (pulse).
module fleet_tick_gen #(
  parameter int STEP_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = enable_i && !clear_i
               && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/monster_fleet_ctrl.sv
// Monster side of the game: kills, score, fleet march and tank loss.
// In: clk, rst, new_game, level_in, hit_valid/hit_idx, tank_hit.
// Out: monster_destroyed, alive_mask, tank_destroyed, score, fleet_x/y/dir.
module monster_fleet_ctrl
  import monster_fleet_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 2500000,
  parameter int X_STEP   = 4,
  parameter int X_LEFT   = 160,
  parameter int X_RIGHT  = 600,
  parameter int Y_TOP    = 80,
  parameter int Y_DROP   = 16,
  parameter int Y_TANK   = 400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_game,
  input  logic [2:0]   level_in,
  input  logic         hit_valid,
  input  logic [2:0]   hit_idx,
  input  logic         tank_hit,
  output logic [4:0]   monster_destroyed,
  output logic [4:0]   alive_mask,
  output logic         tank_destroyed,
  output logic [3:0]   score,
  output logic [9:0]   fleet_x,
  output logic [9:0]   fleet_y,
  output logic         fleet_dir
);

  localparam fleet_pos_t POS_INIT = {
    10'(X_LEFT), 10'(Y_TOP), 1'b1
  };

  localparam logic [10:0] XSTEP_W = 11'(X_STEP);
  localparam logic [10:0] XRGT_W  = 11'(X_RIGHT);
  localparam logic [10:0] XLB_W   = 11'(X_LEFT + X_STEP);
  localparam logic [9:0]  XSTEP_V = 10'(X_STEP);
  localparam logic [9:0]  YDROP_V = 10'(Y_DROP);
  localparam logic [9:0]  YTANK_V = 10'(Y_TANK);

  logic [4:0] alive_q, alive_d;
  logic [4:0] dead_q, dead_d;
  logic [3:0] score_q, score_d;
  logic       tank_q, tank_d;
  fleet_pos_t pos_q, pos_d;

  load_e      load_sel;
  logic       frozen;
  logic       tick;
  logic [4:0] hit_oh;
  logic       hit_ok;
  logic       bounce;
  logic [9:0] y_drop;
  logic       unused_lvl;

  assign unused_lvl = ^level_in[2:1];

  always_comb begin
    load_sel = LD_NONE;
    priority case (1'b1)
      new_game:    load_sel = LD_L1;
      level_in[0]: load_sel = LD_L2;
      default:     load_sel = LD_NONE;
    endcase
  end

  assign frozen = tank_q || (alive_q == '0);

  // Out-of-range indices decode to no slot.
  assign hit_oh = (hit_idx <= 3'd4)
                ? (5'b00001 << hit_idx)
                : 5'b00000;

  assign hit_ok = hit_valid
               && |(hit_oh & alive_q);

  // Bounce tests are done one bit wider so
  // the sum never wraps before comparison.
  assign bounce = pos_q.dir
    ? (({1'b0, pos_q.x} + XSTEP_W) > XRGT_W)
    : ({1'b0, pos_q.x} < XLB_W);

  assign y_drop = pos_q.y + YDROP_V;

  fleet_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .enable_i (!frozen),
    .clear_i  (load_sel != LD_NONE),
    .tick_o   (tick)
  );

  always_comb begin
    alive_d = alive_q;
    dead_d  = dead_q;
    score_d = score_q;
    tank_d  = tank_q;
    pos_d   = pos_q;
    unique case (load_sel)
      LD_L1: begin
        alive_d = L1_MASK;
        dead_d  = '0;
        score_d = '0;
        tank_d  = 1'b0;
        pos_d   = POS_INIT;
      end
      LD_L2: begin
        alive_d = L2_MASK;
        dead_d  = '0;
        pos_d   = POS_INIT;
      end
      default: begin
        if (!frozen) begin
          if (hit_ok) begin
            alive_d = alive_q & ~hit_oh;
            dead_d  = dead_q | hit_oh;
            score_d = sat_inc(score_q);
          end
          if (tank_hit) begin
            tank_d = 1'b1;
          end
          if (tick) begin
            if (bounce) begin
              pos_d.dir = !pos_q.dir;
              pos_d.y   = y_drop;
              // Reaching the tank row ends
              // the game on the drop edge.
              if (y_drop >= YTANK_V) begin
                tank_d = 1'b1;
              end
            end else if (pos_q.dir) begin
              pos_d.x = pos_q.x + XSTEP_V;
            end else begin
              pos_d.x = pos_q.x - XSTEP_V;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q <= L1_MASK;
      dead_q  <= '0;
      score_q <= '0;
      tank_q  <= 1'b0;
      pos_q   <= POS_INIT;
    end else begin
      alive_q <= alive_d;
      dead_q  <= dead_d;
      score_q <= score_d;
      tank_q  <= tank_d;
      pos_q   <= pos_d;
    end
  end

  assign monster_destroyed = dead_q;
  assign alive_mask        = alive_q;
  assign tank_destroyed    = tank_q;
  assign score             = score_q;
  assign fleet_x           = pos_q.x;
  assign fleet_y           = pos_q.y;
  assign fleet_dir         = pos_q.dir;

endmodule
